number_dealer: RTL and testbench
================================

// Module: number_dealer
// PURPOSE
//   Deals one round of the 24 game: draws SLOTS card values (1..MAX_VAL) from an LFSR by rejection
//   sampling, then publishes them as numbers_concat to the VGA display path. Sits upstream of vga/screen.
//   Commit is frame-synchronous, on a frame_start strobe, so screen never renders a half-updated hand.
// PARAMETERS
//   SLOTS    4        cards per hand
//   SLOT_W   12       bits per slot in numbers_concat (SLOTS*SLOT_W = 48)
//   MAX_VAL  13       largest accepted card value (1..15)
//   SEED     16'hACE1 LFSR reset value; 0 is replaced by 16'h0001
// PORTS
//   clk_100m        in   1              system clock, 100 MHz
//   rst             in   1              synchronous reset, active-high
//   deal            in   1              one-cycle deal request, already debounced
//   frame_start     in   1              one-cycle strobe at start of vertical blanking, clk_100m domain
//   numbers_concat  out  SLOTS*SLOT_W   committed hand; slot i at [i*SLOT_W +: SLOT_W]
//   busy            out  1              high in DRAW or WAIT
//   hand_valid      out  1              high once at least one hand has been committed
// BEHAVIOUR
//   Reset: numbers_concat=0, busy=0, hand_valid=0, state=IDLE, lfsr=SEED, slot index=0, shadow=0.
//   LFSR: 16-bit Galois, right shift, mask 16'hB400: nxt = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
//   FSM states:
//   - IDLE: deal=1 -> DRAW, index=0. frame_start is ignored.
//   - DRAW: each cycle, c = lfsr[3:0] (current value) and lfsr steps.
//     - 1<=c<=MAX_VAL: shadow[index] = c zero-extended to SLOT_W; index++.
//     - Otherwise: reject, index unchanged.
//     - On accepting slot SLOTS-1 -> WAIT.
//   - WAIT: frame_start=1 -> numbers_concat<=shadow and hand_valid<=1, both visible the next cycle; -> IDLE.
//   Latency: DRAW >= SLOTS cycles and unbounded in principle (the LFSR period guarantees progress).
//     Commit happens on the first frame_start sampled in WAIT.
//   Requests:
//     - deal while busy is ignored, not queued.
//     - deal and frame_start together in WAIT: commit only, deal dropped.
//     - frame_start on the same cycle as the final DRAW acceptance is not a commit; the next one is.
//   numbers_concat changes only on commit cycles and is stable at all other times.
//   busy is registered: high the cycle after deal is accepted, low the cycle after commit.
//   Reset mid-DRAW or mid-WAIT: the partial hand is discarded; all reset values are restored.
// CONFIGURATION
//   DEALER_FREE_RUN_EN defined: the LFSR steps every cycle in every state. The human timing of deal
//     supplies entropy; the hand is non-deterministic at system level.
//   Not defined: the LFSR steps only in DRAW. The deal sequence is fully deterministic from SEED.
// TESTING (DEALER_FREE_RUN_EN undefined, default params)
//   - Reset, deal pulse:
//     - 6 DRAW cycles: accept 1, reject 0, accept 8, 12, reject 14, accept 7; then WAIT.
//     - Next frame_start -> numbers_concat=48'h007_00C_008_001, hand_valid=1, busy=0; lfsr=16'hB313.
//   - Second deal without reset: the next hand is drawn starting from lfsr=16'hB313.
//     - Golden-model compare of all 4 slots; each slot in 1..13.
//   - deal pulses during DRAW and WAIT -> no restart, no extra hand; exactly one commit per accepted deal.
//   - Commit timing:
//     - frame_start held low 10k cycles in WAIT -> numbers_concat unchanged.
//     - Strobe -> update in exactly 1 cycle.
//   - rst asserted mid-DRAW -> next cycle all outputs 0, lfsr=16'hACE1.
//     - Following deal reproduces 48'h007_00C_008_001.
//   - 1000 random deals with random frame_start spacing:
//     - Every committed slot in 1..MAX_VAL; numbers_concat changes only on commit cycles.

Source files
------------

// File: rtl/number_dealer.sv
// Deals one 24-game hand: draws SLOTS card values from a Galois LFSR by rejection sampling, then
// commits them on frame_start. Define DEALER_FREE_RUN_EN to let the LFSR step every cycle in every state.
module number_dealer #(
    parameter int          SLOTS   = 4,
    parameter int          SLOT_W  = 12,
    parameter int          MAX_VAL = 13,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                      clk_100m,
    input  logic                      rst,
    input  logic                      deal,
    input  logic                      frame_start,
    output logic [SLOTS*SLOT_W-1:0]   numbers_concat,
    output logic                      busy,
    output logic                      hand_valid
);

    // state  | meaning
    // S_IDLE | no hand in progress, waiting for deal
    // S_DRAW | pulling one LFSR nibble per cycle into the shadow hand
    // S_WAIT | shadow hand complete, waiting for frame_start to commit

    localparam int          IDX_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  MAX_C    = 4'(MAX_VAL);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_WAIT} state_t;

    state_t                    state_q;
    logic [15:0]               lfsr_q;
    logic [15:0]               lfsr_d;
    logic [IDX_W-1:0]          idx_q;
    logic [SLOTS*SLOT_W-1:0]   shadow_q;
    logic [SLOTS*SLOT_W-1:0]   concat_q;
    logic                      busy_q;
    logic                      valid_q;

    logic [3:0] card;
    logic       card_ok;
    logic       last_slot;
    logic       lfsr_step;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    assign card      = lfsr_q[3:0];
    assign card_ok   = (card != 4'd0) && (card <= MAX_C);
    assign last_slot = (idx_q == IDX_W'(SLOTS - 1));

`ifdef DEALER_FREE_RUN_EN
    assign lfsr_step = 1'b1;
`else
    assign lfsr_step = (state_q == S_DRAW);
`endif

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED_EFF;
            idx_q    <= '0;
            shadow_q <= '0;
            concat_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (lfsr_step) begin
                lfsr_q <= lfsr_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (deal) begin
                        state_q <= S_DRAW;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_DRAW: begin
                    if (card_ok) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                shadow_q[i*SLOT_W +: SLOT_W] <= {{(SLOT_W-4){1'b0}}, card};
                            end
                        end
                        idx_q <= idx_q + 1'b1;
                        if (last_slot) begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // deal arriving alongside the strobe is dropped, not queued
                    if (frame_start) begin
                        concat_q <= shadow_q;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign numbers_concat = concat_q;
    assign busy           = busy_q;
    assign hand_valid     = valid_q;

endmodule

// File: tb/tb_number_dealer.sv
// Randomized bench for number_dealer against a hand-level reference model (default build).
module tb_number_dealer;

    logic        clk_100m = 1'b0;
    logic        rst = 1'b1;
    logic        deal = 1'b0;
    logic        frame_start = 1'b0;
    logic [47:0] numbers_concat;
    logic        busy;
    logic        hand_valid;

    localparam logic [47:0] GOLDEN = 48'h007_00C_008_001;

    always #5 clk_100m = ~clk_100m;

    number_dealer dut (
        .clk_100m       (clk_100m),
        .rst            (rst),
        .deal           (deal),
        .frame_start    (frame_start),
        .numbers_concat (numbers_concat),
        .busy           (busy),
        .hand_valid     (hand_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;
    logic [47:0] m_concat;
    logic        m_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Draw a whole hand from the model LFSR; ncyc is the number of DRAW cycles used.
    task automatic model_draw(inout logic [15:0] s, output logic [47:0] hand, output int ncyc);
        int k;
        int c;
        k = 0;
        ncyc = 0;
        hand = '0;
        while (k < 4) begin
            c = int'(s[3:0]);
            s = lfsr_next(s);
            ncyc++;
            if (c >= 1 && c <= 13) begin
                hand[k*12 +: 12] = 12'(c);
                k++;
            end
        end
    endtask

    task automatic check_slots();
        int v;
        for (int i = 0; i < 4; i++) begin
            v = int'(numbers_concat[i*12 +: 12]);
            check("slot_range", 64'(v >= 1 && v <= 13), 64'd1);
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            frame_start = ($urandom_range(0, 1) == 1);
            @(negedge clk_100m);
            frame_start = 1'b0;
            check("idle_concat", 64'(numbers_concat), 64'(m_concat));
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_valid", 64'(hand_valid), 64'(m_valid));
        end
    endtask

    // mode 0: random strobes/deals; 1: strobe on final accept then 3 later; 2: 10k-cycle hold in WAIT
    task automatic run_hand(input int mode);
        logic [47:0] hand;
        int  n;
        int  j;
        bit  fs;
        bit  dl;
        bit  commit;
        bit  done;
        model_draw(m_lfsr, hand, n);
        deal = 1'b1;
        frame_start = (mode == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
        @(negedge clk_100m);
        deal = 1'b0;
        frame_start = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
        check("concat_hold", 64'(numbers_concat), 64'(m_concat));
        j = 0;
        done = 1'b0;
        while (!done) begin
            j++;
            case (mode)
                0: begin
                    fs = ($urandom_range(0, 2) == 0) || (j > n + 50);
                    dl = ($urandom_range(0, 3) == 0);
                end
                1: begin
                    fs = (j == n) || (j == n + 3);
                    dl = (j == 2);
                end
                default: begin
                    fs = (j == n) || (j == n + 10000);
                    dl = (j == 5000);
                end
            endcase
            deal = dl;
            frame_start = fs;
            @(negedge clk_100m);
            deal = 1'b0;
            frame_start = 1'b0;
            commit = fs && (j > n);
            if (commit) begin
                m_concat = hand;
                m_valid  = 1'b1;
            end
            check("concat", 64'(numbers_concat), 64'(m_concat));
            check("hand_valid", 64'(hand_valid), 64'(m_valid));
            check("busy", 64'(busy), 64'(!commit));
            if (commit) begin
                done = 1'b1;
                check_slots();
            end else if (j > n + 10100) begin
                check("timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
    endtask

    initial begin
        m_lfsr   = 16'hACE1;
        m_concat = '0;
        m_valid  = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk_100m);
        check("rst_concat", 64'(numbers_concat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(hand_valid), 64'd0);
        rst = 1'b0;

        run_hand(1);
        check("hand1_golden", 64'(numbers_concat), 64'(GOLDEN));
        idle_cycles(2);
        run_hand(1);
        idle_cycles(3);
        run_hand(2);
        idle_cycles(1);

        // reset two cycles into DRAW
        deal = 1'b1;
        @(negedge clk_100m);
        deal = 1'b0;
        repeat (2) @(negedge clk_100m);
        rst = 1'b1;
        @(negedge clk_100m);
        check("midrst_concat", 64'(numbers_concat), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(hand_valid), 64'd0);
        rst = 1'b0;
        m_lfsr   = 16'hACE1;
        m_concat = '0;
        m_valid  = 1'b0;
        run_hand(1);
        check("postrst_golden", 64'(numbers_concat), 64'(GOLDEN));

        repeat (1000) begin
            idle_cycles($urandom_range(0, 3));
            run_hand(0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
